// File: rtl/fft_r22sdf_twiddle_mult_pkg.sv
// Shared constants and elaboration-time helpers for the R2^2 SDF twiddle multiplier.
// Twiddle words are generated at elaboration time, so no external memory image is needed.
package fft_r22sdf_twiddle_mult_pkg;

    localparam real Pi = 3.14159265358979323846;

    // Quarter index q (top two bits of k) selects the twiddle exponent multiplier m.
    localparam logic [1:0] QuarterToM [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint tw_one(input int unsigned tww);
        return longint'(1) << (tww - 2);
    endfunction

    function automatic longint tw_round(input int unsigned tww);
        return longint'(1) << (tww - 3);
    endfunction

    function automatic int round_to_int(input real v);
        if (v >= 0.0) begin
            return $rtoi(v + 0.5);
        end
        return $rtoi(v - 0.5);
    endfunction

    // Packed {re, im} word for W_L^e; only the low 2*tww bits are meaningful.
    function automatic logic [63:0] tw_word(input int unsigned e, input int unsigned l,
                                            input int unsigned tww);
        real th;
        real one;
        int re_i;
        int im_i;
        logic [63:0] mask;
        th = 2.0 * Pi * real'(e) / real'(l);
        one = real'(tw_one(tww));
        re_i = round_to_int(one * $cos(th));
        im_i = round_to_int(-one * $sin(th));
        mask = (64'd1 << tww) - 64'd1;
        return ((64'(re_i) & mask) << tww) | (64'(im_i) & mask);
    endfunction

endpackage

// File: rtl/fft_r22sdf_twiddle_mult_rom.sv
// Twiddle ROM: DEPTH words of {re, im}, one registered read port, no reset.
// Contents are computed at elaboration from the block length L.
module fft_r22sdf_twiddle_mult_rom
    import fft_r22sdf_twiddle_mult_pkg::*;
#(
    parameter int unsigned L     = 16,
    parameter int unsigned TWW   = 25,
    parameter int unsigned DEPTH = 12,
    parameter int unsigned AW    = 4
) (
    input  logic              clk_i,
    input  logic [AW-1:0]     i_addr,
    output logic [2*TWW-1:0]  o_data
);

    logic [2*TWW-1:0] w_table [DEPTH];
    logic [2*TWW-1:0] r_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        localparam logic [63:0] Word = tw_word(g, L, TWW);
        assign w_table[g] = Word[2*TWW-1:0];
    end

    always_ff @(posedge clk_i) begin
        r_data <= w_table[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/fft_r22sdf_twiddle_mult.sv
// Twiddle multiplier between R2^2 SDF stages: block position tracking, twiddle lookup
// and a 4-cycle complex multiply with round-half-up and saturation.
module fft_r22sdf_twiddle_mult
    import fft_r22sdf_twiddle_mult_pkg::*;
#(
    parameter int unsigned N     = 1024,
    parameter int unsigned STAGE = 0,
    parameter int unsigned DW    = 25,
    parameter int unsigned TWW   = 25
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic          start_i,
    input  logic [DW-1:0] x_re_i,
    input  logic [DW-1:0] x_im_i,
    output logic          valid_o,
    output logic [DW-1:0] z_re_o,
    output logic [DW-1:0] z_im_o
);

    localparam int unsigned L     = N >> (2 * STAGE);
    localparam int unsigned KW    = clog2(L);
    localparam int unsigned NW    = KW - 2;
    localparam int unsigned DEPTH = 3 * L / 4;
    localparam int unsigned PW    = DW + TWW;
    localparam int unsigned SW    = PW + 1;
    localparam int unsigned OW    = SW - (TWW - 2);

    localparam logic signed [SW-1:0] RoundK = SW'(tw_round(TWW));
    localparam logic signed [OW-1:0] SatMax = OW'((longint'(1) << (DW - 1)) - 1);
    localparam logic signed [OW-1:0] SatMin = OW'(-(longint'(1) << (DW - 1)));

    // Block position and twiddle exponent
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_cur;
    logic [1:0]    w_m;
    logic [NW-1:0] w_n;
    logic [KW-1:0] w_e;

    always_comb begin
        w_k_cur = (valid_i && start_i) ? '0 : r_k;
        w_m     = QuarterToM[w_k_cur[KW-1 -: 2]];
        w_n     = w_k_cur[NW-1:0];
        w_e     = (w_m[1] ? {1'b0, w_n, 1'b0} : '0) + (w_m[0] ? {2'b00, w_n} : '0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_k <= '0;
        end else if (valid_i) begin
            r_k <= w_k_cur + KW'(1);
        end
    end

    // c1: capture sample and exponent
    logic signed [DW-1:0] r_x1_re, r_x1_im;
    logic [KW-1:0]        r_e1;
    logic                 r_v1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x1_re <= '0;
            r_x1_im <= '0;
            r_e1    <= '0;
            r_v1    <= 1'b0;
        end else begin
            r_x1_re <= x_re_i;
            r_x1_im <= x_im_i;
            r_e1    <= w_e;
            r_v1    <= valid_i;
        end
    end

    // c2: registered ROM read alongside the delayed sample
    logic [2*TWW-1:0]      w_tw;
    logic signed [TWW-1:0] w_tw_re, w_tw_im;
    logic signed [DW-1:0]  r_x2_re, r_x2_im;
    logic                  r_v2;

    fft_r22sdf_twiddle_mult_rom #(
        .L     (L),
        .TWW   (TWW),
        .DEPTH (DEPTH),
        .AW    (KW)
    ) u_rom (
        .clk_i  (clk_i),
        .i_addr (r_e1),
        .o_data (w_tw)
    );

    assign w_tw_re = w_tw[2*TWW-1:TWW];
    assign w_tw_im = w_tw[TWW-1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x2_re <= '0;
            r_x2_im <= '0;
            r_v2    <= 1'b0;
        end else begin
            r_x2_re <= r_x1_re;
            r_x2_im <= r_x1_im;
            r_v2    <= r_v1;
        end
    end

    // c3: partial products, (a + jb)(c + jd)
    logic signed [PW-1:0] r_ac, r_bd, r_ad, r_bc;
    logic                 r_v3;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ac <= '0;
            r_bd <= '0;
            r_ad <= '0;
            r_bc <= '0;
            r_v3 <= 1'b0;
        end else begin
            r_ac <= PW'(r_x2_re) * PW'(w_tw_re);
            r_bd <= PW'(r_x2_im) * PW'(w_tw_im);
            r_ad <= PW'(r_x2_re) * PW'(w_tw_im);
            r_bc <= PW'(r_x2_im) * PW'(w_tw_re);
            r_v3 <= r_v2;
        end
    end

    // c4: combine, round, rescale and saturate
    logic signed [SW-1:0] w_re_rnd, w_im_rnd;
    logic signed [OW-1:0] w_re_sh, w_im_sh;
    logic [DW-1:0]        w_re_sat, w_im_sat;
    logic                 w_unused_lsb;

    always_comb begin
        w_re_rnd = SW'(r_ac) - SW'(r_bd) + RoundK;
        w_im_rnd = SW'(r_ad) + SW'(r_bc) + RoundK;
        // Taking the upper bits is the arithmetic shift right by TWW-2.
        w_re_sh  = w_re_rnd[SW-1:TWW-2];
        w_im_sh  = w_im_rnd[SW-1:TWW-2];

        if (w_re_sh > SatMax) begin
            w_re_sat = SatMax[DW-1:0];
        end else if (w_re_sh < SatMin) begin
            w_re_sat = SatMin[DW-1:0];
        end else begin
            w_re_sat = w_re_sh[DW-1:0];
        end

        if (w_im_sh > SatMax) begin
            w_im_sat = SatMax[DW-1:0];
        end else if (w_im_sh < SatMin) begin
            w_im_sat = SatMin[DW-1:0];
        end else begin
            w_im_sat = w_im_sh[DW-1:0];
        end
    end

    assign w_unused_lsb = ^{w_re_rnd[TWW-3:0], w_im_rnd[TWW-3:0]};

    logic [DW-1:0] r_z_re, r_z_im;
    logic          r_v4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_z_re <= '0;
            r_z_im <= '0;
            r_v4   <= 1'b0;
        end else begin
            r_v4 <= r_v3;
            if (r_v3) begin
                r_z_re <= w_re_sat;
                r_z_im <= w_im_sat;
            end
        end
    end

    assign valid_o = r_v4;
    assign z_re_o  = r_z_re;
    assign z_im_o  = r_z_im;

endmodule

// File: tb/tb_fft_r22sdf_twiddle_mult.sv
// Directed bench for the twiddle multiplier at L=16 (N=16, STAGE=0, DW=TWW=25).
// Inputs and their expected block positions are logged; outputs are collected at negedge.
module tb_fft_r22sdf_twiddle_mult;

    localparam int MAXV = 16777215;
    localparam int MINV = -16777216;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        start = 1'b0;
    logic [24:0] x_re = '0;
    logic [24:0] x_im = '0;
    logic        valid_o;
    logic [24:0] z_re;
    logic [24:0] z_im;

    fft_r22sdf_twiddle_mult #(
        .N     (16),
        .STAGE (0),
        .DW    (25),
        .TWW   (25)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid),
        .start_i (start),
        .x_re_i  (x_re),
        .x_im_i  (x_im),
        .valid_o (valid_o),
        .z_re_o  (z_re),
        .z_im_o  (z_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int in_re_q[$], in_im_q[$], in_k_q[$], in_cyc_q[$];
    int out_re_q[$], out_im_q[$], out_cyc_q[$];
    int kmodel = 0;
    int n_checks = 0;
    int n_pass = 0;
    int mtab[4] = '{0, 2, 1, 3};

    always @(negedge clk) begin
        if (valid_o === 1'b1) begin
            out_re_q.push_back(int'($signed(z_re)));
            out_im_q.push_back(int'($signed(z_im)));
            out_cyc_q.push_back(cyc);
        end
    end

    function automatic int clampr(input real v);
        real r;
        r = $floor(v + 0.5);
        if (r > 16777215.0) return MAXV;
        if (r < -16777216.0) return MINV;
        return $rtoi(r);
    endfunction

    function automatic void model(input int xr, input int xi, input int k,
                                  output int er, output int ei);
        int  e;
        real th;
        e  = mtab[k / 4] * (k % 4);
        th = 2.0 * 3.14159265358979 * real'(e) / 16.0;
        er = clampr(real'(xr) * $cos(th) + real'(xi) * $sin(th));
        ei = clampr(real'(xi) * $cos(th) - real'(xr) * $sin(th));
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic step(input logic v, input logic s, input int xr, input int xi);
        int kk;
        valid = v;
        start = s;
        x_re  = xr[24:0];
        x_im  = xi[24:0];
        if (rst) begin
            kmodel = 0;
        end else if (v) begin
            kk = s ? 0 : kmodel;
            in_re_q.push_back(xr);
            in_im_q.push_back(xi);
            in_k_q.push_back(kk);
            in_cyc_q.push_back(cyc);
            kmodel = (kk + 1) % 16;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 0);
    endtask

    task automatic clear_q();
        in_re_q.delete();
        in_im_q.delete();
        in_k_q.delete();
        in_cyc_q.delete();
        out_re_q.delete();
        out_im_q.delete();
        out_cyc_q.delete();
    endtask

    task automatic send_block(input int xr, input int xi, input int len);
        step(1'b1, 1'b1, xr, xi);
        for (int i = 1; i < len; i++) step(1'b1, 1'b0, xr, xi);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), int'($urandom), int'($urandom));
            n_checks++;
            if (valid_o !== 1'b0) $display("FAIL reset_valid cyc %0d: got %b want 0", i, valid_o);
            else n_pass++;
            n_checks++;
            if (z_re !== 25'd0) $display("FAIL reset_z_re cyc %0d: got %h want 0", i, z_re);
            else n_pass++;
            n_checks++;
            if (z_im !== 25'd0) $display("FAIL reset_z_im cyc %0d: got %h want 0", i, z_im);
            else n_pass++;
        end
        rst = 1'b0;
        idle(2);
        n_checks++;
        if (out_re_q.size() !== 0)
            $display("FAIL reset_no_output: got %0d outputs want 0", out_re_q.size());
        else n_pass++;
    endtask

    task automatic test_identity();
        int er, ei;
        clear_q();
        send_block(1000, -500, 16);
        idle(6);
        n_checks++;
        if (out_re_q.size() !== 16)
            $display("FAIL identity_count: got %0d want 16", out_re_q.size());
        else n_pass++;
        for (int i = 0; i < 16 && i < out_re_q.size(); i++) begin
            n_checks++;
            if (out_cyc_q[i] - in_cyc_q[i] !== 4)
                $display("FAIL identity_latency k=%0d: got %0d want 4", i,
                         out_cyc_q[i] - in_cyc_q[i]);
            else n_pass++;
            if (i <= 4 || i == 8 || i == 12) begin
                n_checks++;
                if (out_re_q[i] !== 1000 || out_im_q[i] !== -500)
                    $display("FAIL identity_exact k=%0d: got (%0d,%0d) want (1000,-500)", i,
                             out_re_q[i], out_im_q[i]);
                else n_pass++;
            end
        end
        // Output must hold the last product (k=15) once valid_o drops.
        model(1000, -500, 15, er, ei);
        n_checks++;
        if (valid_o !== 1'b0 || absdiff(int'($signed(z_re)), er) > 1 ||
            absdiff(int'($signed(z_im)), ei) > 1)
            $display("FAIL identity_hold: got v=%b (%0d,%0d) want v=0 (%0d,%0d)", valid_o,
                     $signed(z_re), $signed(z_im), er, ei);
        else n_pass++;
    endtask

    task automatic test_quarter();
        int er, ei;
        clear_q();
        send_block(1048576, 0, 16);
        idle(6);
        n_checks++;
        if (out_re_q.size() !== 16)
            $display("FAIL quarter_count: got %0d want 16", out_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 16) begin
            n_checks++;
            if (out_re_q[5] !== 741455 || out_im_q[5] !== -741455)
                $display("FAIL quarter_k5_exact: got (%0d,%0d) want (741455,-741455)",
                         out_re_q[5], out_im_q[5]);
            else n_pass++;
            model(1048576, 0, 5, er, ei);
            n_checks++;
            if (absdiff(out_re_q[5], er) > 1 || absdiff(out_im_q[5], ei) > 1)
                $display("FAIL quarter_k5_model: got (%0d,%0d) want (%0d,%0d)",
                         out_re_q[5], out_im_q[5], er, ei);
            else n_pass++;
            model(1048576, 0, 13, er, ei);
            n_checks++;
            if (absdiff(out_re_q[13], er) > 1 || absdiff(out_im_q[13], ei) > 1)
                $display("FAIL quarter_k13_model: got (%0d,%0d) want (%0d,%0d)",
                         out_re_q[13], out_im_q[13], er, ei);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int er, ei;
        int bad;
        // Positive full scale
        clear_q();
        send_block(MAXV, MAXV, 16);
        idle(6);
        n_checks++;
        if (out_re_q.size() !== 16)
            $display("FAIL sat_max_count: got %0d want 16", out_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 16) begin
            n_checks++;
            if (out_re_q[5] !== MAXV || out_im_q[5] !== 0)
                $display("FAIL sat_max_k5: got (%0d,%0d) want (%0d,0)", out_re_q[5],
                         out_im_q[5], MAXV);
            else n_pass++;
            n_checks++;
            if (out_re_q[6] !== MAXV || out_im_q[6] !== -MAXV)
                $display("FAIL sat_max_k6: got (%0d,%0d) want (%0d,%0d)", out_re_q[6],
                         out_im_q[6], MAXV, -MAXV);
            else n_pass++;
            bad = -1;
            for (int i = 0; i < 16; i++) begin
                model(MAXV, MAXV, i, er, ei);
                if (absdiff(out_re_q[i], er) > 3 || absdiff(out_im_q[i], ei) > 3) bad = i;
            end
            n_checks++;
            if (bad !== -1) $display("FAIL sat_max_model: got mismatch at k=%0d want none", bad);
            else n_pass++;
        end
        // Negative full scale
        clear_q();
        send_block(MINV, MINV, 16);
        idle(6);
        n_checks++;
        if (out_re_q.size() !== 16)
            $display("FAIL sat_min_count: got %0d want 16", out_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 16) begin
            n_checks++;
            if (out_re_q[0] !== MINV || out_im_q[0] !== MINV)
                $display("FAIL sat_min_k0: got (%0d,%0d) want (%0d,%0d)", out_re_q[0],
                         out_im_q[0], MINV, MINV);
            else n_pass++;
            n_checks++;
            if (out_re_q[5] !== MINV || out_im_q[5] !== 0)
                $display("FAIL sat_min_k5: got (%0d,%0d) want (%0d,0)", out_re_q[5],
                         out_im_q[5], MINV);
            else n_pass++;
            n_checks++;
            if (out_re_q[6] !== MINV || out_im_q[6] !== MAXV)
                $display("FAIL sat_min_k6: got (%0d,%0d) want (%0d,%0d)", out_re_q[6],
                         out_im_q[6], MINV, MAXV);
            else n_pass++;
            bad = -1;
            for (int i = 0; i < 16; i++) begin
                model(MINV, MINV, i, er, ei);
                if (absdiff(out_re_q[i], er) > 3 || absdiff(out_im_q[i], ei) > 3) bad = i;
            end
            n_checks++;
            if (bad !== -1) $display("FAIL sat_min_model: got mismatch at k=%0d want none", bad);
            else n_pass++;
        end
    endtask

    task automatic test_gaps_resync();
        int er, ei;
        int bad;
        clear_q();
        for (int i = 0; i < 26; i++) begin
            // Sample 7 lands on k=7 and is forced back to k=0.
            step(1'b1, (i == 0 || i == 7), 3000 + 17 * i, -1500 + 29 * i);
            if (i == 3) step(1'b0, 1'b1, 0, 0);
            idle($urandom_range(0, 2));
        end
        idle(6);
        n_checks++;
        if (out_re_q.size() !== in_re_q.size())
            $display("FAIL gaps_count: got %0d want %0d", out_re_q.size(), in_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 26 && in_re_q.size() >= 26) begin
            n_checks++;
            if (out_re_q[7] !== 3119 || out_im_q[7] !== -1297)
                $display("FAIL gaps_resync_k0: got (%0d,%0d) want (3119,-1297)", out_re_q[7],
                         out_im_q[7]);
            else n_pass++;
            bad = -1;
            for (int i = 0; i < 26; i++) begin
                model(in_re_q[i], in_im_q[i], in_k_q[i], er, ei);
                if (absdiff(out_re_q[i], er) > 1 || absdiff(out_im_q[i], ei) > 1) bad = i;
            end
            n_checks++;
            if (bad !== -1) $display("FAIL gaps_model: got mismatch at sample %0d want none", bad);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int er, ei;
        int bad;
        clear_q();
        for (int i = 0; i < 6; i++) step(1'b1, (i == 0), 500 + 100 * i, 200 - 50 * i);
        rst = 1'b1;
        step(1'b1, 1'b0, 9999, 9999);
        rst = 1'b0;
        idle(8);
        n_checks++;
        if (out_re_q.size() !== 3)
            $display("FAIL rstmid_flushed: got %0d outputs want 3", out_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 3) begin
            bad = -1;
            for (int i = 0; i < 3; i++) begin
                model(in_re_q[i], in_im_q[i], in_k_q[i], er, ei);
                if (absdiff(out_re_q[i], er) > 1 || absdiff(out_im_q[i], ei) > 1) bad = i;
            end
            n_checks++;
            if (bad !== -1) $display("FAIL rstmid_pre: got mismatch at sample %0d want none", bad);
            else n_pass++;
        end
        clear_q();
        for (int i = 0; i < 8; i++) step(1'b1, (i == 0), 700 - 90 * i, -300 + 70 * i);
        idle(6);
        n_checks++;
        if (out_re_q.size() !== 8)
            $display("FAIL rstmid_post_count: got %0d want 8", out_re_q.size());
        else n_pass++;
        if (out_re_q.size() >= 8) begin
            n_checks++;
            if (out_re_q[0] !== 700 || out_im_q[0] !== -300)
                $display("FAIL rstmid_post_k0: got (%0d,%0d) want (700,-300)", out_re_q[0],
                         out_im_q[0]);
            else n_pass++;
            bad = -1;
            for (int i = 0; i < 8; i++) begin
                model(in_re_q[i], in_im_q[i], i, er, ei);
                if (absdiff(out_re_q[i], er) > 1 || absdiff(out_im_q[i], ei) > 1) bad = i;
            end
            n_checks++;
            if (bad !== -1) $display("FAIL rstmid_post: got mismatch at k=%0d want none", bad);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_quarter();
        test_saturation();
        test_gaps_resync();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
